// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one data-memory port between the CPU MEM
// stage and a burst DMA engine. The CPU normally wins. A pending DMA beat is
// forced through after STARVE_LIMIT consecutive CPU wins, so a burst always
// makes progress.
//
// Handshake semantics: the memory port is combinational. In any cycle exactly
// one side owns it. The CPU request is cpu_re|cpu_we, and cpu_stall=1 means
// "not served this cycle, hold the request". A DMA beat is served in the cycle
// dma_wready (write) or mem_re with the beat address (read) is high. Read-beat
// data returns one cycle later with dma_rvalid.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_start,
  input  logic        dma_write,
  input  logic [31:0] dma_base,
  input  logic [4:0]  dma_len,
  input  logic [31:0] dma_wdata,
  output logic        dma_wready,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_busy,
  output logic        dma_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [4:0]    left_q, left_d;
  logic          write_q, write_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic       cpu_req;
  logic       in_burst;
  logic       starved;
  logic       dma_win;
  logic       cpu_win;
  logic [4:0] len_eff;

  // Grant decision. While reset is high the block behaves as if idle and
  // makes no memory access.
  always_comb begin
    cpu_req  = cpu_re | cpu_we;
    in_burst = (state_q == BURST) && !reset;
    starved  = (starve_q >= SW'(STARVE_LIMIT));
    dma_win  = in_burst && (!cpu_req || starved);
    cpu_win  = cpu_req && !dma_win && !reset;
    len_eff  = (dma_len > 5'd16) ? 5'd16 : dma_len;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a zero-length start skips straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dma_start) begin
          state_d = (dma_len == 5'd0) ? DONE : BURST;
        end
      end
      BURST: begin
        if (dma_win && (left_q == 5'd1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: memory port mux from the winner, stall and status flags
  always_comb begin
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    dma_wready = 1'b0;
    cpu_rdata  = 32'd0;
    if (dma_win) begin
      mem_addr = addr_q;
      if (write_q) begin
        mem_we     = 1'b1;
        mem_wdata  = dma_wdata;
        dma_wready = 1'b1;
      end else begin
        mem_re = 1'b1;
      end
    end else if (cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = cpu_re & ~cpu_we;
      if (cpu_re && !cpu_we) begin
        cpu_rdata = mem_rdata;
      end
    end
    cpu_stall  = cpu_req && dma_win;
    dma_busy   = (state_q == BURST) || (state_q == DONE);
    dma_done   = (state_q == DONE);
    dma_rdata  = rdata_q;
    dma_rvalid = rvalid_q;
    dbg_state  = state_q;
  end

  // Burst bookkeeping: latch on start, advance address on each beat,
  // starve counter counts CPU wins since the last beat
  always_comb begin
    addr_d   = addr_q;
    left_d   = left_q;
    write_d  = write_q;
    starve_d = starve_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if ((state_q == IDLE) && dma_start && (dma_len != 5'd0)) begin
      addr_d  = dma_base;
      write_d = dma_write;
      left_d  = len_eff;
    end
    if (dma_win) begin
      addr_d   = addr_q + 32'd4;
      left_d   = left_q - 5'd1;
      starve_d = '0;
      if (!write_q) begin
        rdata_d  = mem_rdata;
        rvalid_d = 1'b1;
      end
    end else if (in_burst && cpu_win) begin
      starve_d = starve_q + SW'(1);
    end
    if (state_d != BURST) begin
      starve_d = '0;
    end
  end

  // Burst datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= 32'd0;
      left_q   <= 5'd0;
      write_q  <= 1'b0;
      starve_q <= '0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      left_q   <= left_d;
      write_q  <= write_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a reference model advances one cycle per driven
// input vector and pushes the expected outputs; a negedge monitor pops and
// compares them against the DUT.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_start = 1'b0, dma_write = 1'b0;
  logic [31:0] dma_base = '0;
  logic [4:0]  dma_len = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_wready;
  logic [31:0] dma_rdata;
  logic        dma_rvalid, dma_busy, dma_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_start(dma_start), .dma_write(dma_write), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_wready(dma_wready), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Data memory: 256 words, aliased on addr[9:2], async read, write on edge
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  assign mem_rdata = ram[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        stall, wready, rvalid, busy, done, we, re;
    logic        chk_addr, chk_wdata, chk_crd;
    logic [31:0] addr, wdata, crd, drd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  exp_t mon_e;
  // Monitor: one expected record per driven cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk_bit("cpu_stall", cpu_stall, mon_e.stall);
      chk_bit("dma_wready", dma_wready, mon_e.wready);
      chk_bit("dma_rvalid", dma_rvalid, mon_e.rvalid);
      chk_bit("dma_busy", dma_busy, mon_e.busy);
      chk_bit("dma_done", dma_done, mon_e.done);
      chk_bit("mem_we", mem_we, mon_e.we);
      chk_bit("mem_re", mem_re, mon_e.re);
      if (mon_e.chk_addr)  chk_word("mem_addr", mem_addr, mon_e.addr);
      if (mon_e.chk_wdata) chk_word("mem_wdata", mem_wdata, mon_e.wdata);
      if (mon_e.chk_crd)   chk_word("cpu_rdata", cpu_rdata, mon_e.crd);
      if (mon_e.rvalid)    chk_word("dma_rdata", dma_rdata, mon_e.drd);
    end
  end

  // ---------------- reference model ----------------
  int          m_phase = 0;   // 0 idle, 1 burst, 2 done
  int          m_left = 0, m_idx = 0, m_streak = 0;
  logic [31:0] m_base = '0;
  logic        m_write = 1'b0;
  logic [31:0] m_words [16];
  logic        m_rv = 1'b0;
  logic [31:0] m_rvd = '0;
  logic [31:0] drv_base = '0;
  logic [4:0]  drv_len = '0;
  logic        drv_write = 1'b0;

  // Drive one cycle of inputs and push what the outputs must be in that cycle
  task automatic step(input logic rst, input logic start, input logic cre, input logic cwe,
                      input logic [31:0] caddr, input logic [31:0] cwd);
    exp_t        e;
    logic        req, dwin, cwin, next_rv;
    logic [31:0] a, rvd_n;
    int          clamp;
    @(posedge clk);
    #1;
    reset = rst; dma_start = start; cpu_re = cre; cpu_we = cwe;
    cpu_addr = caddr; cpu_wdata = cwd;
    dma_base = drv_base; dma_len = drv_len; dma_write = drv_write;
    dma_wdata = (m_phase == 1) ? m_words[m_idx] : $urandom();
    e = '0;
    e.busy = (m_phase != 0);
    e.done = (m_phase == 2);
    e.rvalid = m_rv;
    e.drd = m_rvd;
    req  = cre | cwe;
    dwin = !rst && (m_phase == 1) && !(req && (m_streak < LIMIT));
    cwin = !rst && req && !dwin;
    e.stall = req && dwin;
    e.chk_addr = !rst;
    next_rv = 1'b0;
    rvd_n = '0;
    if (dwin) begin
      a = m_base + 32'(4 * m_idx);
      e.addr = a;
      if (m_write) begin
        e.we = 1'b1; e.wready = 1'b1; e.chk_wdata = 1'b1; e.wdata = m_words[m_idx];
        ref_mem[a[9:2]] = m_words[m_idx];
      end else begin
        e.re = 1'b1; next_rv = 1'b1; rvd_n = ref_mem[a[9:2]];
      end
    end else if (cwin) begin
      e.addr = caddr;
      if (cwe) begin
        e.we = 1'b1; e.chk_wdata = 1'b1; e.wdata = cwd;
        ref_mem[caddr[9:2]] = cwd;
      end else begin
        e.re = 1'b1; e.chk_crd = 1'b1; e.crd = ref_mem[caddr[9:2]];
      end
    end
    exp_q.push_back(e);
    if (rst) begin
      m_phase = 0; m_rv = 1'b0; m_rvd = '0; m_streak = 0;
    end else begin
      m_rv = next_rv;
      if (next_rv) m_rvd = rvd_n;
      case (m_phase)
        0: if (start) begin
          clamp = (drv_len > 5'd16) ? 16 : int'(drv_len);
          if (clamp == 0) m_phase = 2;
          else begin
            m_phase = 1; m_left = clamp; m_idx = 0; m_streak = 0;
            m_base = drv_base; m_write = drv_write;
          end
        end
        1: if (dwin) begin
          m_idx++; m_left--; m_streak = 0;
          if (m_left == 0) m_phase = 2;
        end else begin
          m_streak++;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  // CPU traffic per mode: 0 none, 1 reads held high, 2 random reads/writes
  task automatic cpu_step(input int mode, input logic rst, input logic start);
    logic        cre, cwe;
    logic [31:0] ca;
    ca  = 32'h200 + 32'(4 * $urandom_range(0, 31));
    cre = (mode == 1) || ((mode == 2) && ($urandom_range(0, 1) == 1));
    cwe = (mode == 2) && ($urandom_range(0, 2) == 0);
    step(rst, start, cre, cwe, ca, $urandom());
  endtask

  task automatic run_burst(input logic [31:0] base, input logic [4:0] len, input logic wr,
                           input int mode, input int abort_at);
    int guard;
    drv_base = base; drv_len = len; drv_write = wr;
    for (int i = 0; i < 16; i++) m_words[i] = $urandom();
    cpu_step(mode, 1'b0, 1'b1);
    guard = 0;
    while (m_phase != 0 && guard < 400) begin
      guard++;
      if (abort_at >= 0 && m_phase == 1 && m_idx == abort_at)
        cpu_step(0, 1'b1, 1'b0);
      else
        cpu_step(mode, 1'b0, (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    if (guard >= 400) begin
      n_tests++; n_fail++;
      $display("FAIL burst_timeout: burst still open after %0d cycles", guard);
    end
    cpu_step(0, 1'b0, 1'b0);
    cpu_step(mode, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = {16'hA5A5, 8'h00, 8'(i)};
      ref_mem[i] = {16'hA5A5, 8'h00, 8'(i)};
    end
    // reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, '0);
    // CPU-only store then load
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, '0);
    // write burst, then read it back under continuous CPU reads
    run_burst(32'h100, 5'd4, 1'b1, 0, -1);
    run_burst(32'h100, 5'd3, 1'b0, 1, -1);
    // zero length and clamped length
    run_burst(32'h300, 5'd0, 1'b1, 0, -1);
    run_burst(32'h400, 5'd20, 1'b1, 0, -1);
    run_burst(32'h400, 5'd31, 1'b0, 1, -1);
    // address wrap
    run_burst(32'hFFFF_FFF8, 5'd3, 1'b1, 2, -1);
    run_burst(32'hFFFF_FFF8, 5'd3, 1'b0, 0, -1);
    // reset mid-burst, then a fresh burst
    run_burst(32'h500, 5'd8, 1'b1, 0, 2);
    cpu_step(0, 1'b0, 1'b0);
    run_burst(32'h500, 5'd8, 1'b0, 0, -1);
    // randomized bursts with random CPU traffic and stray starts
    for (int n = 0; n < 25; n++) begin
      run_burst($urandom() & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), ($urandom_range(0, 5) == 0) ? 1 : -1);
    end
    repeat (3) @(posedge clk);
    chk_word("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
